// File: rtl/sample_capture_buffer.sv
// sample_capture_buffer
//   Capture stage behind the measurement system controller. Samples from the
//   controller (in_data / in_data_vld) are stored during the execute window
//   (qualified by clken) into a DEPTH-word RAM. Once DEPTH samples are held,
//   firmware drains them in order with a one-word-per-cycle read request.
//   A clear pulse rearms the block for a new run.
//
// Ports
//   clk, rstn            : clock, asynchronous active-low reset
//   clken                : capture window enable from the controller
//   clear                : single-cycle rearm pulse, returns to IDLE
//   in_data, in_data_vld : sample stream from the controller
//   rd_en                : firmware read request, one word per asserted cycle
//   rd_data, rd_data_vld : read word, valid one cycle after an accepted rd_en
//   wr_count             : samples stored in the current run (0..DEPTH)
//   buf_full             : wr_count == DEPTH
//   rd_done              : every stored word has been read out
//   event_wr_when_not_capturing : pulse, sample offered outside CAPTURE
//   event_rd_when_not_ready     : pulse, read requested outside READOUT
//   state                : FSM state (0 IDLE, 1 CAPTURE, 2 READOUT, 3 DONE)
//
// Handshake: in_data is taken on a clock edge only when in CAPTURE with
// in_data_vld=1 and clken=1; there is no back-pressure, samples offered in any
// other state are dropped and flagged. A read request is accepted on an edge
// whenever rd_en=1 in READOUT; the word appears with rd_data_vld=1 right after
// that edge. Requests outside READOUT are dropped and flagged.
module sample_capture_buffer #(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 1024,
   localparam int ADDR_WIDTH = $clog2(DEPTH),
   localparam int CNT_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clken,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_data_vld,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_vld,
   output logic [CNT_WIDTH-1:0]  wr_count,
   output logic                  buf_full,
   output logic                  rd_done,
   output logic                  event_wr_when_not_capturing,
   output logic                  event_rd_when_not_ready,
   output logic [1:0]            state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      READOUT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                cur_state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic wr_accept;
   logic rd_accept;

   // rd_ptr is ADDR_WIDTH wide, so it is always below DEPTH while in READOUT;
   // the state change on the last read is what stops further reads.
   assign wr_accept = (cur_state == CAPTURE) && in_data_vld && clken && !clear;
   assign rd_accept = (cur_state == READOUT) && rd_en && !clear;
   assign state     = cur_state;

   // RAM write port, no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cur_state                   <= IDLE;
         wr_ptr                      <= '0;
         rd_ptr                      <= '0;
         wr_count                    <= '0;
         rd_data                     <= '0;
         rd_data_vld                 <= 1'b0;
         buf_full                    <= 1'b0;
         rd_done                     <= 1'b0;
         event_wr_when_not_capturing <= 1'b0;
         event_rd_when_not_ready     <= 1'b0;
      end else if (clear) begin
         // rd_data keeps its last value; only the valid flag drops.
         cur_state                   <= IDLE;
         wr_ptr                      <= '0;
         rd_ptr                      <= '0;
         wr_count                    <= '0;
         rd_data_vld                 <= 1'b0;
         buf_full                    <= 1'b0;
         rd_done                     <= 1'b0;
         event_wr_when_not_capturing <= 1'b0;
         event_rd_when_not_ready     <= 1'b0;
      end else begin
         rd_data_vld                 <= 1'b0;
         event_wr_when_not_capturing <= 1'b0;
         event_rd_when_not_ready     <= 1'b0;
         case (cur_state)
            IDLE: begin
               event_wr_when_not_capturing <= in_data_vld;
               event_rd_when_not_ready     <= rd_en;
               if (clken) begin
                  cur_state <= CAPTURE;
               end
            end
            CAPTURE: begin
               // clken low pauses the run silently: no write, no event.
               event_rd_when_not_ready <= rd_en;
               if (wr_accept) begin
                  wr_ptr   <= wr_ptr + ADDR_WIDTH'(1);
                  wr_count <= wr_count + CNT_WIDTH'(1);
                  if (wr_count == CNT_WIDTH'(DEPTH - 1)) begin
                     buf_full  <= 1'b1;
                     cur_state <= READOUT;
                  end
               end
            end
            READOUT: begin
               event_wr_when_not_capturing <= in_data_vld;
               if (rd_accept) begin
                  rd_data     <= mem[rd_ptr];
                  rd_data_vld <= 1'b1;
                  rd_ptr      <= rd_ptr + ADDR_WIDTH'(1);
                  if (rd_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                     rd_done   <= 1'b1;
                     cur_state <= DONE;
                  end
               end
            end
            DONE: begin
               event_wr_when_not_capturing <= in_data_vld;
               event_rd_when_not_ready     <= rd_en;
            end
            default: begin
               cur_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Directed bench for sample_capture_buffer (DEPTH=1024, DATA_WIDTH=32).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each check sees the result of the edge just taken.
module tb_sample_capture_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 1024;
   localparam int CW    = 11;

   logic          clk = 1'b0;
   logic          rstn;
   logic          clken;
   logic          clear;
   logic [DW-1:0] in_data;
   logic          in_data_vld;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_data_vld;
   logic [CW-1:0] wr_count;
   logic          buf_full;
   logic          rd_done;
   logic          ev_wr;
   logic          ev_rd;
   logic [1:0]    state;

   int tests_run = 0;
   int tests_failed = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_word;

   localparam logic [1:0] S_IDLE = 2'd0, S_CAP = 2'd1, S_RD = 2'd2, S_DONE = 2'd3;

   sample_capture_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk                         (clk),
      .rstn                        (rstn),
      .clken                       (clken),
      .clear                       (clear),
      .in_data                     (in_data),
      .in_data_vld                 (in_data_vld),
      .rd_en                       (rd_en),
      .rd_data                     (rd_data),
      .rd_data_vld                 (rd_data_vld),
      .wr_count                    (wr_count),
      .buf_full                    (buf_full),
      .rd_done                     (rd_done),
      .event_wr_when_not_capturing (ev_wr),
      .event_rd_when_not_ready     (ev_rd),
      .state                       (state)
   );

   // ---- clock ----
   always #5 clk = ~clk;

   // ---- driver helpers ----
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " state"},    32'(state), 32'(S_IDLE));
      check({tag, " wr_count"}, 32'(wr_count), 32'd0);
      check({tag, " buf_full"}, 32'(buf_full), 32'd0);
      check({tag, " rd_done"},  32'(rd_done), 32'd0);
      check({tag, " rd_vld"},   32'(rd_data_vld), 32'd0);
      check({tag, " ev_wr"},    32'(ev_wr), 32'd0);
      check({tag, " ev_rd"},    32'(ev_rd), 32'd0);
   endtask

   // Capture n samples base+i with clken held high; optional pause of 10
   // cycles with clken low every 100 samples.
   task automatic capture_run(input logic [DW-1:0] base, input int n, input bit pauses);
      for (int i = 0; i < n; i++) begin
         if (pauses && i > 0 && (i % 100) == 0) begin
            clken = 1'b0;
            in_data_vld = 1'b1;
            in_data = 32'hBAD0_0000 | 32'(i);
            for (int p = 0; p < 10; p++) begin
               tick();
               check("pause wr_count", 32'(wr_count), 32'(i));
               check("pause ev_wr", 32'(ev_wr), 32'd0);
            end
            clken = 1'b1;
         end
         in_data = base + 32'(i);
         in_data_vld = 1'b1;
         tick();
         exp_q.push_back(base + 32'(i));
         check("cap wr_count", 32'(wr_count), 32'(i + 1));
         check("cap state", 32'(state), (i + 1 == DEPTH) ? 32'(S_RD) : 32'(S_CAP));
         check("cap buf_full", 32'(buf_full), (i + 1 == DEPTH) ? 32'd1 : 32'd0);
      end
      in_data_vld = 1'b0;
   endtask

   // Back-to-back reads; every valid word is checked against the queue.
   task automatic read_words(input int n);
      for (int i = 0; i < n; i++) begin
         rd_en = 1'b1;
         tick();
         check("rd vld", 32'(rd_data_vld), 32'd1);
         if (exp_q.size() == 0) begin
            check("rd queue empty", 32'd1, 32'd0);
         end else begin
            exp_word = exp_q.pop_front();
            check("rd data", rd_data, exp_word);
         end
      end
      rd_en = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; clken = 1'b0; clear = 1'b0;
      in_data = '0; in_data_vld = 1'b0; rd_en = 1'b0;
      #12;
      check_idle_outputs("reset");
      check("reset rd_data", rd_data, 32'd0);
      rstn = 1'b1;
      tick();
      check("idle after reset", 32'(state), 32'(S_IDLE));

      // rd_en in IDLE flags an event one cycle later, no read
      rd_en = 1'b1;
      tick();
      check("idle rd ev_rd", 32'(ev_rd), 32'd1);
      check("idle rd vld", 32'(rd_data_vld), 32'd0);
      rd_en = 1'b0;
      tick();
      check("idle rd ev_rd drop", 32'(ev_rd), 32'd0);

      // Enter CAPTURE with a sample on the same cycle: dropped and flagged
      clken = 1'b1; in_data_vld = 1'b1; in_data = 32'hDEAD_BEEF;
      tick();
      check("enter cap state", 32'(state), 32'(S_CAP));
      check("enter cap wr_count", 32'(wr_count), 32'd0);
      check("enter cap ev_wr", 32'(ev_wr), 32'd1);
      in_data_vld = 1'b0;

      // Partial run of 500 samples, aborted by clear
      capture_run(32'd0, 500, 1'b0);
      check("partial wr_count", 32'(wr_count), 32'd500);

      // rd_en during CAPTURE: one pulse per offending cycle
      rd_en = 1'b1;
      tick();
      check("cap rd ev_rd 1", 32'(ev_rd), 32'd1);
      tick();
      check("cap rd ev_rd 2", 32'(ev_rd), 32'd1);
      check("cap rd vld", 32'(rd_data_vld), 32'd0);
      rd_en = 1'b0;
      tick();
      check("cap rd ev_rd drop", 32'(ev_rd), 32'd0);
      check("cap rd wr_count", 32'(wr_count), 32'd500);

      // clear with a coincident write: write discarded, back to IDLE
      clear = 1'b1; in_data_vld = 1'b1; in_data = 32'h5555_5555;
      tick();
      clear = 1'b0; in_data_vld = 1'b0; clken = 1'b0;
      exp_q.delete();
      check_idle_outputs("clear");
      tick();
      check("clear stays idle", 32'(state), 32'(S_IDLE));

      // Full rerun 0x1000+i with clken pauses
      clken = 1'b1;
      tick();
      check("rerun state", 32'(state), 32'(S_CAP));
      check("rerun ev_wr", 32'(ev_wr), 32'd0);
      capture_run(32'h1000, DEPTH, 1'b1);
      check("full wr_count", 32'(wr_count), 32'd1024);

      // Sample offered in READOUT is dropped and flagged
      in_data_vld = 1'b1; in_data = 32'hFFFF_0000;
      tick();
      check("rdout ev_wr", 32'(ev_wr), 32'd1);
      check("rdout wr_count", 32'(wr_count), 32'd1024);
      in_data_vld = 1'b0;
      tick();
      check("rdout ev_wr drop", 32'(ev_wr), 32'd0);
      check("rdout no vld", 32'(rd_data_vld), 32'd0);

      // Drain all 1024 words back to back
      read_words(DEPTH);
      check("drain state", 32'(state), 32'(S_DONE));
      check("drain rd_done", 32'(rd_done), 32'd1);
      check("drain buf_full", 32'(buf_full), 32'd1);
      tick();
      check("hold vld", 32'(rd_data_vld), 32'd0);
      check("hold data", rd_data, 32'h13FF);
      check("hold rd_done", 32'(rd_done), 32'd1);

      // Events in DONE
      in_data_vld = 1'b1;
      tick();
      check("done ev_wr", 32'(ev_wr), 32'd1);
      check("done ev_rd quiet", 32'(ev_rd), 32'd0);
      in_data_vld = 1'b0; rd_en = 1'b1;
      tick();
      check("done ev_rd", 32'(ev_rd), 32'd1);
      check("done ev_wr drop", 32'(ev_wr), 32'd0);
      check("done rd vld", 32'(rd_data_vld), 32'd0);
      check("done rd data", rd_data, 32'h13FF);
      rd_en = 1'b0;
      tick();
      check("done ev_rd drop", 32'(ev_rd), 32'd0);
      check("done wr_count", 32'(wr_count), 32'd1024);

      // Clear from DONE, rerun with data = index, then partial readout
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_idle_outputs("clear2");
      clken = 1'b1;
      tick();
      capture_run(32'd0, DEPTH, 1'b0);
      read_words(20);
      // Read issued right before a clear still yields its valid pulse
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      clear = 1'b1;
      check("pre-clear vld", 32'(rd_data_vld), 32'd1);
      check("pre-clear data", rd_data, 32'd20);
      tick();
      clear = 1'b0;
      check_idle_outputs("clear3");
      exp_q.delete();

      // Third run, then async reset between edges mid-readout
      tick();
      capture_run(32'h2000, DEPTH, 1'b0);
      read_words(5);
      rd_en = 1'b1;
      #3;
      rstn = 1'b0;
      #1;
      check_idle_outputs("async rst");
      check("async rst rd_data", rd_data, 32'd0);
      rd_en = 1'b0; clken = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      tick();
      check("post rst idle", 32'(state), 32'(S_IDLE));
      clken = 1'b1;
      tick();
      check("post rst capture", 32'(state), 32'(S_CAP));
      check("post rst wr_count", 32'(wr_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #2000000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sample_capture_buffer.md
Name: sample_capture_buffer

Overview:
- Capture stage directly downstream of the measurement system controller.
- Stores the `out_data`/`out_data_vld` sample stream produced during the execute window (qualified by the controller's `clken`) into an on-chip RAM of DEPTH words.
- Once the buffer is full, firmware drains it in order through a simple read-request handshake.
- A clear pulse from the restart path (REDO/RECONFIG/CLOSE) rearms the block for a new run.

Parameters:
- DATA_WIDTH, 32, sample width in bits.
- DEPTH, 1024, number of samples per run; must be a power of two and at least 4.
- ADDR_WIDTH, $clog2(DEPTH), local; RAM address width.
- CNT_WIDTH, ADDR_WIDTH+1, local; counter width, so DEPTH itself is representable.

Ports:
- clk  input  1  system clock.
- rstn  input  1  reset, asynchronous, active-low.
- clken  input  1  capture window enable from system controller.
- clear  input  1  single-cycle rearm pulse; any state -> IDLE.
- in_data  input  DATA_WIDTH  sample from controller out_data.
- in_data_vld  input  1  sample valid from controller out_data_vld.
- rd_en  input  1  firmware read request, one word per cycle asserted.
- rd_data  output  DATA_WIDTH  read word.
- rd_data_vld  output  1  rd_data valid, 1 cycle after accepted rd_en.
- wr_count  output  CNT_WIDTH  samples stored in current run.
- buf_full  output  1  wr_count == DEPTH.
- rd_done  output  1  all DEPTH words read out.
- event_wr_when_not_capturing  output  1  pulse: in_data_vld while not in CAPTURE with clken=1.
- event_rd_when_not_ready  output  1  pulse: rd_en outside READOUT.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, wr_ptr=0, rd_ptr=0, wr_count=0, rd_data=0, rd_data_vld=0, buf_full=0, rd_done=0, both events=0. RAM contents are not reset.
- States: IDLE(0), CAPTURE(1), READOUT(2), DONE(3); 2-bit state register; unreachable codes -> IDLE.
- IDLE: clken=1 -> CAPTURE next cycle. A sample presented in that same cycle is not written.
- CAPTURE: write when in_data_vld & clken. mem[wr_ptr]<=in_data; wr_ptr++ and wr_count++ on the same edge.
  - Write with wr_count==DEPTH-1 -> wr_count=DEPTH, buf_full=1, state=READOUT on that edge.
  - clken dropping mid-capture pauses the run: state holds, in_data_vld is ignored, no event is raised.
- READOUT: accepted read = rd_en & (rd_ptr < DEPTH).
  - rd_data<=mem[rd_ptr], rd_data_vld=1 on the next cycle; rd_ptr++.
  - Back-to-back reads give 1 word/cycle.
  - rd_en=0 -> rd_data_vld=0 next cycle; rd_data holds its last value.
  - Accepted read at rd_ptr==DEPTH-1 -> state=DONE on that edge; the last rd_data_vld appears in the first DONE cycle.
- DONE: rd_done=1, buf_full stays 1, held until clear. rd_en here -> event_rd_when_not_ready.
- Events: registered, asserted one cycle after the offending input cycle, one cycle wide per offending cycle.
  - event_wr_when_not_capturing: in_data_vld=1 in IDLE, READOUT or DONE; such data is dropped.
  - event_rd_when_not_ready: rd_en=1 in IDLE, CAPTURE or DONE; no read performed, rd_data_vld stays 0.
- clear: highest priority below reset; synchronous. On the next edge: state=IDLE, pointers, wr_count, buf_full, rd_done and rd_data_vld all 0.
  - A write or read coincident with clear is discarded.
  - A read issued the cycle before clear still produces its rd_data_vld pulse.
- Pointer arithmetic:
  - wr_ptr/rd_ptr are ADDR_WIDTH wide and wrap to 0 naturally at DEPTH.
  - wr_count never exceeds DEPTH; no overflow is possible because writes stop in READOUT.
- RAM: single write port, single synchronous read port, inferable as block RAM.

Test Plan:
- Reset, clken=1, DEPTH=1024, in_data_vld=1 each cycle with data=index 0..1023 -> buf_full=1 and state READOUT right after write 1023; wr_count=1024.
- Continuous rd_en for 1024 cycles after full -> rd_data_vld 1..1024 cycles after the first rd_en, rd_data=0..1023 in order; rd_done=1 after the last read.
- clken toggled 0 for 10 cycles every 100 samples during capture -> no writes or events while clken=0; final contents still 0..1023 contiguous.
- in_data_vld in DONE and rd_en in CAPTURE -> each event pulses exactly once per offending cycle, one cycle later; memory and pointers unchanged.
- clear at sample 500 of capture, then a full rerun with data 0x1000+index -> wr_count restarts at 0; readout returns 0x1000..0x13FF only.
- rstn dropped asynchronously mid-READOUT (between clock edges) -> all outputs 0 immediately, without waiting for a clk edge; after release the block idles until clken=1.
